dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the far end of the processor's data port: serves ar_out/dm_en/bus_out
//  reads and writes with fixed 1-cycle read latency. Adds a host port (load image before run,
//  dump results after end_process) and owns the LOAD -> RUN -> DONE sequencing plus a run-cycle counter.
// PARAMETERS
//  ADDR_W   12    address width; matches processor ar_out
//  DATA_W   12    word width; matches dm_out
//  DEPTH    4096  words implemented; DEPTH <= 2**ADDR_W
//  CNT_W    24    run-cycle counter width
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  p_addr       in   ADDR_W  processor address (ar_out)
//  p_wdata      in   DATA_W  processor write data (bus_out[DATA_W-1:0])
//  p_we         in   1       processor write strobe (dm_en)
//  p_rdata      out  DATA_W  read data to processor (dm_out)
//  end_process  in   1       processor completion flag
//  proc_start   out  1       high while in RUN; processor held idle otherwise
//  h_req        in   1       host request, held until h_ack
//  h_we         in   1       host write (1) / read (0), valid with h_req
//  h_addr       in   ADDR_W  host address
//  h_wdata      in   DATA_W  host write data
//  h_ack        out  1       one-cycle acknowledge
//  h_rdata      out  DATA_W  host read data, valid with h_ack on reads
//  h_start      in   1       pulse: LOAD -> RUN
//  h_clear      in   1       pulse: DONE -> LOAD
//  state_o      out  2       00 LOAD, 01 RUN, 10 DONE
//  run_cycles   out  CNT_W   cycles spent in last/current RUN
// BEHAVIOUR
//  Reset: state LOAD; p_rdata, h_rdata, run_cycles = 0; h_ack, proc_start = 0. Memory contents
//   not reset (undefined until written).
//  FSM: LOAD --h_start & !h_req--> RUN (run_cycles cleared same edge); RUN --end_process=1--> DONE;
//   DONE --h_clear--> LOAD; all other inputs hold state. h_start while h_req pending: ignored.
//  Port ownership: RUN = processor only; LOAD/DONE = host only. p_we outside RUN: ignored, no write.
//   h_req during RUN: not acked; stays pending and is served after entering DONE.
//  Processor read: p_rdata <= mem[p_addr] every RUN edge (1-cycle latency); holds value outside RUN.
//  Processor write: p_we=1 at edge -> mem[p_addr] <= p_wdata. Same-edge read of same address
//   returns OLD data (read-first).
//  Host access: h_req sampled high with h_ack=0 -> access performed that edge; h_ack=1 next cycle
//   for exactly one cycle, h_rdata = mem[h_addr] (reads). h_req still high the cycle h_ack is high
//   is not a new request; a new request needs h_req low for >=1 cycle (min 2 cycles/transaction).
//  Address >= DEPTH: writes dropped, reads return 0, host still acked.
//  run_cycles: +1 every RUN cycle, saturates at all-ones, frozen in DONE/LOAD until next RUN entry.
//  end_process already high on RUN entry: DONE next edge, run_cycles = 1.
//  rst_n low mid-transaction: h_ack drops immediately; pending host write may or may not land;
//   FSM returns to LOAD.
//  proc_start = (state==RUN), registered, no glitches.
// STRUCTURE
//  Shared package dmem_pkg: state encodings (ST_LOAD/ST_RUN/ST_DONE), default ADDR_W/DATA_W/DEPTH.
//  One sub-module dmem_array: single-port synchronous RAM (we, addr, wdata, rdata, read-first),
//   port mux in top selects processor or host by state; FSM, ack logic, counter in top.
// TESTING
//  Reset, then host writes 0x0AB to addr 5 in LOAD -> h_ack one cycle later; host read 5 -> h_rdata 0x0AB.
//  h_start; RUN: p_addr=5 -> p_rdata 0x0AB next cycle; p_we, addr 6, data 0x123 -> read 6 gives 0x123.
//  Same-edge write 0x777 / read addr 6 -> p_rdata 0x123 that cycle, 0x777 on following read.
//  h_req read during RUN -> no h_ack; end_process after 10 RUN cycles -> DONE, run_cycles=10,
//   pending read then acked with correct data.
//  p_we=1 in LOAD addr 7 -> memory unchanged; h_clear in DONE -> LOAD, proc_start stays 0.
//  rst_n asserted mid-RUN -> state LOAD, outputs zero asynchronously; CNT_W=4 run of 20 cycles -> run_cycles=15.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// default geometry and an address range helper.
package dmem_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 4096;
    localparam int DEF_CNT_W  = 24;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True when a word address refers to an implemented memory location.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data port, host port and run-control signals of the responder.
// The master side is the processor/host environment, the slave side is the
// responder itself.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    // processor data port
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_we;
    logic [DATA_W-1:0] p_rdata;
    logic              end_process;
    logic              proc_start;
    // host port
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_ack;
    logic [DATA_W-1:0] h_rdata;
    // run control and status
    logic              h_start;
    logic              h_clear;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  run_cycles;

    modport master (
        output p_addr, p_wdata, p_we, end_process,
        output h_req, h_we, h_addr, h_wdata, h_start, h_clear,
        input  p_rdata, proc_start, h_ack, h_rdata, state_o, run_cycles
    );

    modport slave (
        input  p_addr, p_wdata, p_we, end_process,
        input  h_req, h_we, h_addr, h_wdata, h_start, h_clear,
        output p_rdata, proc_start, h_ack, h_rdata, state_o, run_cycles
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with registered, read-first output. No reset on
// the storage or the read register so it maps onto block RAM.
module dmem_array #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4096,
    parameter int AW     = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write on we_i; the read register always samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves the processor during RUN and a host port
// during LOAD/DONE from one shared RAM, sequences LOAD -> RUN -> DONE and
// counts the cycles spent in RUN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_responder_if.slave    bus_io
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic              h_done_q, h_done_d;   // current request already served
    logic              h_ack_q, h_ack_d;
    logic              p_live_q, p_live_d;   // p_rdata comes straight from the RAM
    logic              h_live_q, h_live_d;   // h_rdata comes straight from the RAM
    logic [DATA_W-1:0] p_hold_q, p_hold_d;
    logic [DATA_W-1:0] h_hold_q, h_hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              host_access;
    logic              p_in_range, h_in_range;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [DATA_W-1:0] p_rdata_cur, h_rdata_cur;

    assign p_in_range  = addr_in_range(32'(bus_io.p_addr), DEPTH);
    assign h_in_range  = addr_in_range(32'(bus_io.h_addr), DEPTH);
    // A held h_req is one request: once served it must drop before the next.
    assign host_access = bus_io.h_req && !h_done_q && (state_q != ST_RUN);

    // Read data is either the RAM output of the previous edge's access or a
    // held copy, which keeps the RAM itself free of resets and enables.
    assign p_rdata_cur = p_live_q ? ram_rdata : p_hold_q;
    assign h_rdata_cur = h_live_q ? ram_rdata : h_hold_q;

    // Sequencer next state; h_start is ignored while a host request is up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (bus_io.h_start && !bus_io.h_req) state_d = ST_RUN;
            ST_RUN:  if (bus_io.end_process)              state_d = ST_DONE;
            ST_DONE: if (bus_io.h_clear)                  state_d = ST_LOAD;
            default:                                      state_d = ST_LOAD;
        endcase
    end

    // RAM port mux: the processor owns the RAM in RUN, the host otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = bus_io.h_addr[RAM_AW-1:0];
        ram_wdata = bus_io.h_wdata;
        if (state_q == ST_RUN) begin
            ram_we    = bus_io.p_we && p_in_range;
            ram_addr  = bus_io.p_addr[RAM_AW-1:0];
            ram_wdata = bus_io.p_wdata;
        end else begin
            ram_we    = host_access && bus_io.h_we && h_in_range;
        end
    end

    // Next values for read-data tracking, host handshake and run counter.
    always_comb begin
        p_live_d = 1'b0;
        p_hold_d = p_rdata_cur;
        h_live_d = 1'b0;
        h_hold_d = h_rdata_cur;
        h_ack_d  = host_access;
        h_done_d = h_done_q;
        cnt_d    = cnt_q;

        if (state_q == ST_RUN) begin
            p_live_d = p_in_range;
            if (!p_in_range) p_hold_d = '0;
        end

        if (host_access && !bus_io.h_we) begin
            h_live_d = h_in_range;
            if (!h_in_range) h_hold_d = '0;
        end

        if (host_access)       h_done_d = 1'b1;
        else if (!bus_io.h_req) h_done_d = 1'b0;

        if (state_q == ST_LOAD && state_d == ST_RUN) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // All control and output state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            h_done_q <= 1'b0;
            h_ack_q  <= 1'b0;
            p_live_q <= 1'b0;
            h_live_q <= 1'b0;
            p_hold_q <= '0;
            h_hold_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_done_q <= h_done_d;
            h_ack_q  <= h_ack_d;
            p_live_q <= p_live_d;
            h_live_q <= h_live_d;
            p_hold_q <= p_hold_d;
            h_hold_q <= h_hold_d;
            cnt_q    <= cnt_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus_io.p_rdata    = p_rdata_cur;
    assign bus_io.h_rdata    = h_rdata_cur;
    assign bus_io.h_ack      = h_ack_q;
    assign bus_io.proc_start = (state_q == ST_RUN);
    assign bus_io.state_o    = state_q;
    assign bus_io.run_cycles = cnt_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. A small memory (DEPTH 1024 on a 12-bit
// address) exposes out-of-range handling, and a 4-bit run counter exposes
// saturation.
module tb_dmem_responder;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 1024;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dmem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    dmem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host transaction: raise h_req, wait (bounded) for h_ack, drop h_req
    // and leave one idle cycle.
    task automatic host_xfer(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, output logic got_ack,
                             output logic [DATA_W-1:0] rd, output int lat);
        bus.h_req   = 1'b1;
        bus.h_we    = we;
        bus.h_addr  = addr;
        bus.h_wdata = wdata;
        got_ack     = 1'b0;
        rd          = '0;
        lat         = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (bus.h_ack === 1'b1) begin
                got_ack = 1'b1;
                rd      = bus.h_rdata;
                break;
            end
        end
        bus.h_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.p_addr = '0; bus.p_wdata = '0; bus.p_we = 1'b0; bus.end_process = 1'b0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.h_start = 1'b0; bus.h_clear = 1'b0;
        repeat (3) tick();
        checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL reset_state: got %0h expected 0", bus.state_o); end
        checks++; if (bus.p_rdata !== 12'h000) begin failures++; $display("FAIL reset_p_rdata: got %0h expected 0", bus.p_rdata); end
        checks++; if (bus.h_rdata !== 12'h000) begin failures++; $display("FAIL reset_h_rdata: got %0h expected 0", bus.h_rdata); end
        checks++; if (bus.run_cycles !== 4'd0) begin failures++; $display("FAIL reset_run_cycles: got %0d expected 0", bus.run_cycles); end
        checks++; if (bus.h_ack !== 1'b0 || bus.proc_start !== 1'b0) begin failures++; $display("FAIL reset_ack_start: got %b%b expected 00", bus.h_ack, bus.proc_start); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_load();
        logic got; logic [DATA_W-1:0] rd; int lat;
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 12'd5; bus.h_wdata = 12'h0AB;
        tick();
        checks++; if (bus.h_ack !== 1'b1) begin failures++; $display("FAIL host_wr_ack: got %b expected 1", bus.h_ack); end
        tick();
        checks++; if (bus.h_ack !== 1'b0) begin failures++; $display("FAIL ack_one_cycle: got %b expected 0", bus.h_ack); end
        tick();
        checks++; if (bus.h_ack !== 1'b0) begin failures++; $display("FAIL held_req_no_reack: got %b expected 0", bus.h_ack); end
        bus.h_req = 1'b0;
        tick();
        host_xfer(1'b0, 12'd5, '0, got, rd, lat);
        checks++; if (!got || lat != 1 || rd !== 12'h0AB) begin failures++; $display("FAIL host_rd_5: got ack=%b lat=%0d data=%0h expected ack=1 lat=1 data=0ab", got, lat, rd); end
        host_xfer(1'b1, 12'd976, 12'h0CC, got, rd, lat);
        host_xfer(1'b1, 12'd2000, 12'h055, got, rd, lat);
        checks++; if (!got) begin failures++; $display("FAIL oor_wr_ack: got %b expected 1", got); end
        host_xfer(1'b0, 12'd976, '0, got, rd, lat);
        checks++; if (!got || rd !== 12'h0CC) begin failures++; $display("FAIL oor_wr_dropped: got %0h expected 0cc", rd); end
        host_xfer(1'b0, 12'd2000, '0, got, rd, lat);
        checks++; if (!got || rd !== 12'h000) begin failures++; $display("FAIL oor_rd_zero: got ack=%b data=%0h expected ack=1 data=0", got, rd); end
    endtask

    task automatic test_start_blocked();
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 12'd5; bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL start_blocked: got %0h expected 0", bus.state_o); end
        tick();
        bus.h_req = 1'b0;
        tick();
    endtask

    task automatic test_start();
        bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        checks++; if (bus.state_o !== 2'b01 || bus.proc_start !== 1'b1) begin failures++; $display("FAIL enter_run: got state=%0h start=%b expected state=1 start=1", bus.state_o, bus.proc_start); end
    endtask

    task automatic test_proc_rw();
        bus.p_addr = 12'd5;
        tick();
        checks++; if (bus.p_rdata !== 12'h0AB) begin failures++; $display("FAIL proc_rd_5: got %0h expected 0ab", bus.p_rdata); end
        bus.p_addr = 12'd6; bus.p_wdata = 12'h123; bus.p_we = 1'b1;
        tick();
        bus.p_we = 1'b0;
        tick();
        checks++; if (bus.p_rdata !== 12'h123) begin failures++; $display("FAIL proc_wr_rd_6: got %0h expected 123", bus.p_rdata); end
        bus.p_wdata = 12'h777; bus.p_we = 1'b1;
        tick();
        bus.p_we = 1'b0;
        checks++; if (bus.p_rdata !== 12'h123) begin failures++; $display("FAIL read_first: got %0h expected 123", bus.p_rdata); end
        tick();
        checks++; if (bus.p_rdata !== 12'h777) begin failures++; $display("FAIL after_write: got %0h expected 777", bus.p_rdata); end
        bus.p_addr = 12'd2000;
        tick();
        checks++; if (bus.p_rdata !== 12'h000) begin failures++; $display("FAIL proc_oor_rd: got %0h expected 0", bus.p_rdata); end
    endtask

    // Six RUN cycles have elapsed on entry.
    task automatic test_host_during_run();
        logic any_ack;
        any_ack = 1'b0;
        bus.p_addr = 12'd6;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 12'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.h_ack === 1'b1) any_ack = 1'b1;
        end
        checks++; if (any_ack !== 1'b0) begin failures++; $display("FAIL no_ack_in_run: got %b expected 0", any_ack); end
        checks++; if (bus.run_cycles !== 4'd9) begin failures++; $display("FAIL run_count_mid: got %0d expected 9", bus.run_cycles); end
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        bus.p_addr = 12'd5;
        checks++; if (bus.state_o !== 2'b10 || bus.proc_start !== 1'b0) begin failures++; $display("FAIL enter_done: got state=%0h start=%b expected state=2 start=0", bus.state_o, bus.proc_start); end
        checks++; if (bus.run_cycles !== 4'd10) begin failures++; $display("FAIL run_cycles_10: got %0d expected 10", bus.run_cycles); end
        checks++; if (bus.h_ack !== 1'b0) begin failures++; $display("FAIL no_ack_exit_edge: got %b expected 0", bus.h_ack); end
        tick();
        checks++; if (bus.h_ack !== 1'b1 || bus.h_rdata !== 12'h0AB) begin failures++; $display("FAIL pending_rd: got ack=%b data=%0h expected ack=1 data=0ab", bus.h_ack, bus.h_rdata); end
        checks++; if (bus.p_rdata !== 12'h777) begin failures++; $display("FAIL p_rdata_hold: got %0h expected 777", bus.p_rdata); end
        bus.h_req = 1'b0;
        tick();
        checks++; if (bus.h_ack !== 1'b0 || bus.run_cycles !== 4'd10) begin failures++; $display("FAIL done_frozen: got ack=%b cnt=%0d expected ack=0 cnt=10", bus.h_ack, bus.run_cycles); end
    endtask

    task automatic test_load_pwe_ignored();
        logic got; logic [DATA_W-1:0] rd; int lat;
        bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        checks++; if (bus.state_o !== 2'b10) begin failures++; $display("FAIL start_in_done: got %0h expected 2", bus.state_o); end
        bus.h_clear = 1'b1;
        tick();
        bus.h_clear = 1'b0;
        checks++; if (bus.state_o !== 2'b00 || bus.proc_start !== 1'b0) begin failures++; $display("FAIL clear_to_load: got state=%0h start=%b expected state=0 start=0", bus.state_o, bus.proc_start); end
        host_xfer(1'b1, 12'd7, 12'h111, got, rd, lat);
        bus.p_addr = 12'd7; bus.p_wdata = 12'h3C3; bus.p_we = 1'b1;
        tick();
        tick();
        bus.p_we = 1'b0;
        checks++; if (bus.proc_start !== 1'b0) begin failures++; $display("FAIL start_in_load: got %b expected 0", bus.proc_start); end
        host_xfer(1'b0, 12'd7, '0, got, rd, lat);
        checks++; if (!got || rd !== 12'h111) begin failures++; $display("FAIL pwe_in_load: got %0h expected 111", rd); end
    endtask

    task automatic test_saturate();
        bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        checks++; if (bus.state_o !== 2'b01 || bus.run_cycles !== 4'd0) begin failures++; $display("FAIL cnt_cleared: got state=%0h cnt=%0d expected state=1 cnt=0", bus.state_o, bus.run_cycles); end
        repeat (19) tick();
        bus.end_process = 1'b1;
        tick();
        bus.end_process = 1'b0;
        checks++; if (bus.state_o !== 2'b10 || bus.run_cycles !== 4'd15) begin failures++; $display("FAIL saturate_20: got state=%0h cnt=%0d expected state=2 cnt=15", bus.state_o, bus.run_cycles); end
    endtask

    task automatic test_end_on_entry();
        bus.h_clear = 1'b1;
        tick();
        bus.h_clear = 1'b0;
        bus.end_process = 1'b1; bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        checks++; if (bus.state_o !== 2'b01 || bus.run_cycles !== 4'd0) begin failures++; $display("FAIL early_end_entry: got state=%0h cnt=%0d expected state=1 cnt=0", bus.state_o, bus.run_cycles); end
        tick();
        bus.end_process = 1'b0;
        checks++; if (bus.state_o !== 2'b10 || bus.run_cycles !== 4'd1) begin failures++; $display("FAIL early_end_done: got state=%0h cnt=%0d expected state=2 cnt=1", bus.state_o, bus.run_cycles); end
    endtask

    task automatic test_async_reset();
        bus.h_clear = 1'b1;
        tick();
        bus.h_clear = 1'b0;
        bus.h_start = 1'b1;
        tick();
        bus.h_start = 1'b0;
        bus.p_addr = 12'd5;
        tick();
        tick();
        checks++; if (bus.p_rdata !== 12'h0AB || bus.run_cycles !== 4'd2) begin failures++; $display("FAIL pre_reset_run: got data=%0h cnt=%0d expected data=0ab cnt=2", bus.p_rdata, bus.run_cycles); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.state_o !== 2'b00 || bus.proc_start !== 1'b0) begin failures++; $display("FAIL async_rst_state: got state=%0h start=%b expected state=0 start=0", bus.state_o, bus.proc_start); end
        checks++; if (bus.p_rdata !== 12'h000 || bus.run_cycles !== 4'd0) begin failures++; $display("FAIL async_rst_outputs: got data=%0h cnt=%0d expected data=0 cnt=0", bus.p_rdata, bus.run_cycles); end
        tick();
        rst_n = 1'b1;
        tick();
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 12'd5;
        tick();
        checks++; if (bus.h_ack !== 1'b1 || bus.h_rdata !== 12'h0AB) begin failures++; $display("FAIL rd_after_reset: got ack=%b data=%0h expected ack=1 data=0ab", bus.h_ack, bus.h_rdata); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.h_ack !== 1'b0 || bus.h_rdata !== 12'h000) begin failures++; $display("FAIL async_rst_ack: got ack=%b data=%0h expected ack=0 data=0", bus.h_ack, bus.h_rdata); end
        bus.h_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_host_load();
        test_start_blocked();
        test_start();
        test_proc_rw();
        test_host_during_run();
        test_load_pwe_ignored();
        test_saturate();
        test_end_on_entry();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
